// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: classifies one MEM-stage access, runs it on the
// valid/ready data bus, and returns aligned and extended load data or an error code.
module load_store_unit #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  state_dbg
);

  // Bus handshake: a beat completes on a rising edge where mem_valid & mem_ready;
  // mem_valid and every mem_* output stay stable until that edge or the timeout.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(BUS_TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;

  logic          illegal;
  logic          misaligned;
  logic [3:0]    wstrb_next;
  logic [31:0]   wdata_next;
  logic [31:0]   shifted;
  logic [31:0]   load_ext;

  assign state_dbg = state;
  assign stall     = (state == IDLE && req_valid) || state == BUSY;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (req_we) illegal = (req_funct3 >= 3'd3);
    else        illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    case (req_funct3[1:0])
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    wstrb_next = 4'b0000;
    wdata_next = req_wdata;
    case (req_funct3[1:0])
      2'd0: begin
        wstrb_next = 4'b0001 << req_addr[1:0];
        wdata_next = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        wstrb_next = 4'b0011 << req_addr[1:0];
        wdata_next = {2{req_wdata[15:0]}};
      end
      default: begin
        wstrb_next = 4'b1111;
        wdata_next = req_wdata;
      end
    endcase
    if (!req_we) wstrb_next = 4'b0000;
  end

  // funct3[2] set means the unsigned load variants (LBU/LHU).
  always_comb begin
    shifted  = mem_rdata >> {off_q, 3'b000};
    load_ext = mem_rdata;
    case (f3_q[1:0])
      2'd0:    load_ext = f3_q[2] ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = f3_q[2] ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      err       <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (illegal) begin
              err      <= 1'b1;
              err_code <= 2'b11;
              state    <= DONE;
            end else if (misaligned) begin
              err      <= 1'b1;
              err_code <= 2'b01;
              state    <= DONE;
            end else begin
              mem_valid <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wstrb <= wstrb_next;
              mem_wdata <= wdata_next;
              off_q     <= req_addr[1:0];
              f3_q      <= req_funct3;
              wait_cnt  <= '0;
              state     <= BUSY;
            end
          end
        end
        BUSY: begin
          // A ready in the last allowed wait cycle still wins over the timeout.
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            if (!mem_we) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= load_ext;
            end
            state <= DONE;
          end else if (wait_cnt == LAST_WAIT) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            err       <= 1'b1;
            err_code  <= 2'b10;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          rsp_valid <= 1'b0;
          err       <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: each access is expanded into its expected per-cycle
// output trace from the architectural rules, and a negedge process compares the DUT.
module tb_load_store_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, err, mem_valid, mem_ready, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  err_code, state_dbg;
  logic [3:0]  mem_wstrb;

  load_store_unit #(.BUS_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .err(err), .err_code(err_code),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic        st, mv, mwe, rv, er;
    logic [31:0] maddr, mwdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  code;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] h_rdata = 32'd0;
  logic [1:0]  h_code = 2'b00;
  logic [31:0] obs_addr = 32'd0, obs_wdata = 32'd0;
  logic [3:0]  obs_wstrb = 4'd0;
  logic        obs_we = 1'b0;
  int          mv_run = 0, last_run = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t actual=%h required=%h", n, $time, act, exp);
    end
  endtask

  function automatic void push(input logic st, mv, mwe, rv, er,
                               input logic [31:0] ma, mwd, input logic [3:0] ws);
    exp_t e;
    e.st = st; e.mv = mv; e.mwe = mwe; e.rv = rv; e.er = er;
    e.maddr = ma; e.mwdata = mwd; e.wstrb = ws;
    e.rdata = h_rdata; e.code = h_code;
    exp_q.push_back(e);
  endfunction

  // scoreboard / compare process
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall", stall, e.st);
      chk("mem_valid", mem_valid, e.mv);
      if (e.mv) begin
        chk("mem_we", mem_we, e.mwe);
        chk("mem_addr", mem_addr, e.maddr);
        chk("mem_wstrb", mem_wstrb, e.wstrb);
        if (e.mwe) chk("mem_wdata", mem_wdata, e.mwdata);
      end
      chk("rsp_valid", rsp_valid, e.rv);
      chk("err", err, e.er);
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("err_code", err_code, e.code);
    end
    if (mem_valid) begin
      obs_addr = mem_addr; obs_wstrb = mem_wstrb; obs_wdata = mem_wdata; obs_we = mem_we;
      mv_run++;
    end else begin
      if (mv_run != 0) last_run = mv_run;
      mv_run = 0;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    mem_ready = 1'b0; mem_rdata = $urandom;
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step();
  endtask

  // w = number of BUSY cycles with mem_ready low before it rises (w >= T: never).
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int w);
    int nb, off;
    logic bad, mis, ok;
    logic [3:0] ws;
    logic [31:0] wd, ld, mask;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    mem_ready = 1'b0; mem_rdata = $urandom;
    bad = we ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    nb  = 1 << f3[1:0];
    off = int'(addr[1:0]);
    mis = !bad && (off % nb != 0);
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step();
    if (bad || mis) begin
      h_code = bad ? 2'd3 : 2'd1;
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 4'd0);
      step();
      req_valid = 1'b0;
      return;
    end
    for (int i = 0; i < 4; i++) ws[i] = we && (i >= off) && (i < off + nb);
    for (int j = 0; j < 4; j++) wd[8*j +: 8] = wdata[8*(j % nb) +: 8];
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    ld = (rdata >> (8 * off)) & mask;
    if (!f3[2] && nb < 4 && ld[8*nb-1]) ld = ld | ~mask;
    ok = 1'b0;
    for (int k = 0; k < T; k++) begin
      mem_ready = (k == w);
      mem_rdata = (k == w) ? rdata : $urandom;
      push(1'b1, 1'b1, we, 1'b0, 1'b0, {addr[31:2], 2'b00}, wd, ws);
      step();
      if (k == w) begin
        ok = 1'b1;
        break;
      end
    end
    mem_ready = 1'b0; mem_rdata = $urandom;
    if (ok && !we) h_rdata = ld;
    if (!ok) h_code = 2'd2;
    push(1'b0, 1'b0, 1'b0, ok && !we, !ok, 32'd0, 32'd0, 4'd0);
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] r;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
    step();
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step();
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step();
    rst_n = 1'b1;
    idle_cycle();

    run_txn(1'b0, 3'd0, 32'h0000_0103, 32'd0, 32'h80FF_1234, 0);
    chk("lb_rdata", rsp_rdata, 32'hFFFF_FF80);
    chk("lb_addr", obs_addr, 32'h0000_0100);
    chk("lb_wstrb", obs_wstrb, 4'b0000);
    idle_cycle();
    run_txn(1'b0, 3'd5, 32'h0000_0102, 32'd0, 32'hBEEF_0000, 3);
    chk("lhu_rdata", rsp_rdata, 32'h0000_BEEF);
    chk("lhu_run", last_run, 4);
    run_txn(1'b1, 3'd0, 32'h0000_0101, 32'h0000_00AB, 32'd0, 0);
    chk("sb_addr", obs_addr, 32'h0000_0100);
    chk("sb_wstrb", obs_wstrb, 4'b0010);
    chk("sb_wdata", obs_wdata, 32'hABAB_ABAB);
    chk("sb_we", obs_we, 1'b1);
    run_txn(1'b0, 3'd2, 32'h0000_0102, 32'd0, 32'd0, 0);
    chk("lw_mis_code", err_code, 2'b01);
    run_txn(1'b0, 3'd3, 32'h0000_0100, 32'd0, 32'd0, 0);
    chk("ill_code", err_code, 2'b11);
    idle_cycle();
    run_txn(1'b0, 3'd2, 32'h0000_0040, 32'd0, 32'h1234_5678, T + 3);
    chk("to_code", err_code, 2'b10);
    chk("to_run", last_run, T);

    // asynchronous reset in the second BUSY cycle
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h300; mem_ready = 1'b0;
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step();
    push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'd0, 4'd0);
    step();
    rst_n = 1'b0; req_valid = 1'b0; h_rdata = 32'd0; h_code = 2'b00;
    #1;
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_stall", stall, 1'b0);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step();
    rst_n = 1'b1;
    r = $urandom;
    run_txn(1'b0, 3'd2, 32'h0000_0200, 32'd0, r, T - 1);
    chk("post_rst_lw", rsp_rdata, r);

    for (int n = 0; n < 250; n++) begin
      run_txn(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
              $urandom_range(0, T + 1));
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
